// File: rtl/fwht_order_gen.sv
// Index generator for the FWHT datapath: emits one frame of 2^n coefficient indices
// in natural, dyadic, sequency or Gray order over a registered valid/ready stream.
module fwht_order_gen #(
  parameter int L_WIDTH = 12,
  parameter int N_WIDTH = 4
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [1:0]         i_mode,
  input  logic [N_WIDTH-1:0] i_log2n,
  input  logic               i_loop,
  input  logic               i_ready,
  output logic               o_valid,
  output logic [L_WIDTH-1:0] o_index,
  output logic               o_first,
  output logic               o_last,
  output logic               o_busy,
  output logic               o_done
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [1:0] MODE_NATURAL  = 2'd0;
  localparam logic [1:0] MODE_DYADIC   = 2'd1;
  localparam logic [1:0] MODE_SEQUENCY = 2'd2;

  localparam logic [N_WIDTH-1:0] N_MAX = N_WIDTH'(L_WIDTH);

  function automatic logic [L_WIDTH-1:0] low_mask(input logic [N_WIDTH-1:0] n);
    logic [L_WIDTH-1:0] m;
    for (int i = 0; i < L_WIDTH; i++) m[i] = (i < int'(n));
    return m;
  endfunction

  // Full-width reversal puts the low n bits at the top; shifting down lands them at 0.
  function automatic logic [L_WIDTH-1:0] bitrev_n(input logic [L_WIDTH-1:0] x,
                                                  input logic [N_WIDTH-1:0] n);
    logic [L_WIDTH-1:0] r;
    for (int j = 0; j < L_WIDTH; j++) r[j] = x[L_WIDTH-1-j];
    return r >> (L_WIDTH - int'(n));
  endfunction

  function automatic logic [L_WIDTH-1:0] index_of(input logic [L_WIDTH-1:0] k,
                                                  input logic [1:0]         mode,
                                                  input logic [N_WIDTH-1:0] n);
    logic [L_WIDTH-1:0] g;
    g = k ^ (k >> 1);
    case (mode)
      MODE_NATURAL:  return k;
      MODE_DYADIC:   return bitrev_n(k, n);
      MODE_SEQUENCY: return bitrev_n(g, n);
      default:       return g;
    endcase
  endfunction

  logic [1:0]         state_q, state_d;
  logic [L_WIDTH-1:0] k_q, k_d;
  logic [1:0]         mode_q, mode_d;
  logic [N_WIDTH-1:0] n_q, n_d;
  logic               loop_q, loop_d;
  logic [L_WIDTH-1:0] index_q, index_d;
  logic               first_q, first_d;
  logic               last_q, last_d;

  logic [N_WIDTH-1:0] n_clamp;
  logic [L_WIDTH-1:0] k_inc;
  logic               handshake;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    mode_d  = mode_q;
    n_d     = n_q;
    loop_d  = loop_q;
    index_d = index_q;
    first_d = first_q;
    last_d  = last_q;

    n_clamp   = (i_log2n > N_MAX) ? N_MAX : i_log2n;
    k_inc     = (k_q + L_WIDTH'(1)) & low_mask(n_q);
    handshake = (state_q == ST_RUN) && i_ready;

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d = ST_RUN;
          mode_d  = i_mode;
          n_d     = n_clamp;
          loop_d  = i_loop;
          k_d     = '0;
          index_d = '0;
          first_d = 1'b1;
          last_d  = (n_clamp == '0);
        end
      end
      ST_RUN: begin
        if (handshake) begin
          if (last_q && !loop_q) begin
            state_d = ST_DONE;
            first_d = 1'b0;
            last_d  = 1'b0;
          end else begin
            // k_inc wraps to 0 on the last beat, giving a bubble-free restart in loop mode.
            k_d     = k_inc;
            index_d = index_of(k_inc, mode_q, n_q);
            first_d = (k_inc == '0);
            last_d  = (k_inc == low_mask(n_q));
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      mode_q  <= '0;
      n_q     <= '0;
      loop_q  <= 1'b0;
      index_q <= '0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      mode_q  <= mode_d;
      n_q     <= n_d;
      loop_q  <= loop_d;
      index_q <= index_d;
      first_q <= first_d;
      last_q  <= last_d;
    end
  end

  assign o_valid = (state_q == ST_RUN);
  assign o_busy  = (state_q == ST_RUN);
  assign o_done  = (state_q == ST_DONE);
  assign o_index = index_q;
  assign o_first = first_q;
  assign o_last  = last_q;

endmodule

// File: tb/tb_fwht_order_gen.sv
// Bench for fwht_order_gen: directed frames plus random frames, checked against an
// arithmetic model of the four index orders.
module tb_fwht_order_gen;

  localparam int L_WIDTH = 12;
  localparam int N_WIDTH = 4;

  logic               i_clk;
  logic               i_reset;
  logic               i_start;
  logic [1:0]         i_mode;
  logic [N_WIDTH-1:0] i_log2n;
  logic               i_loop;
  logic               i_ready;
  logic               o_valid;
  logic [L_WIDTH-1:0] o_index;
  logic               o_first;
  logic               o_last;
  logic               o_busy;
  logic               o_done;

  int total = 0;
  int bad   = 0;

  fwht_order_gen #(.L_WIDTH(L_WIDTH), .N_WIDTH(N_WIDTH)) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_start (i_start),
    .i_mode  (i_mode),
    .i_log2n (i_log2n),
    .i_loop  (i_loop),
    .i_ready (i_ready),
    .o_valid (o_valid),
    .o_index (o_index),
    .o_first (o_first),
    .o_last  (o_last),
    .o_busy  (o_busy),
    .o_done  (o_done)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic int rev_bits(input int x, input int n);
    int r;
    r = 0;
    for (int b = 0; b < n; b++) r = (r << 1) | ((x >> b) & 1);
    return r;
  endfunction

  function automatic int ref_idx(input int mode, input int n, input int k);
    int g;
    g = k ^ (k >> 1);
    case (mode)
      0:       return k;
      1:       return rev_bits(k, n);
      2:       return rev_bits(g, n);
      default: return g;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 32'(o_valid), 32'd0);
    chk({tag, "_index"}, 32'(o_index), 32'd0);
    chk({tag, "_first"}, 32'(o_first), 32'd0);
    chk({tag, "_last"},  32'(o_last),  32'd0);
    chk({tag, "_busy"},  32'(o_busy),  32'd0);
    chk({tag, "_done"},  32'(o_done),  32'd0);
  endtask

  // beats < 0 runs the whole frame; otherwise the frame is cut by reset after that many handshakes.
  task automatic run_frame(input int mode, input int log2n, input bit loop,
                           input int rdy_pct, input int stall_at, input int beats);
    int n_eff, nn, k, hs, target, idle_run, stalls;
    bit rdy;
    n_eff    = (log2n > L_WIDTH) ? L_WIDTH : log2n;
    nn       = 1 << n_eff;
    target   = (beats < 0) ? nn : beats;
    k        = 0;
    hs       = 0;
    idle_run = 0;
    stalls   = 0;
    i_mode   = 2'(mode);
    i_log2n  = N_WIDTH'(log2n);
    i_loop   = loop;
    i_start  = 1'b1;
    i_ready  = 1'b0;
    @(negedge i_clk);
    while (hs < target) begin
      chk("valid", 32'(o_valid), 32'd1);
      chk("index", 32'(o_index), 32'(ref_idx(mode, n_eff, k)));
      chk("first", 32'(o_first), 32'(k == 0));
      chk("last",  32'(o_last),  32'(k == nn - 1));
      chk("busy",  32'(o_busy),  32'd1);
      chk("done",  32'(o_done),  32'd0);
      if (stall_at == hs && stalls < 3) begin
        rdy = 1'b0;
        stalls++;
      end else if (idle_run >= 4) begin
        rdy = 1'b1;
      end else begin
        rdy = ($urandom_range(99) < rdy_pct);
      end
      i_ready = rdy;
      // Config and start noise while running must have no effect on the frame.
      i_start = ($urandom_range(3) == 0);
      i_mode  = 2'($urandom);
      i_log2n = N_WIDTH'($urandom);
      i_loop  = 1'($urandom);
      @(negedge i_clk);
      if (rdy) begin
        hs++;
        k = (k + 1) % nn;
        idle_run = 0;
      end else begin
        idle_run++;
      end
    end
    i_start = 1'b0;
    i_ready = 1'b0;
    if (!loop && beats < 0) begin
      chk("end_done",   32'(o_done),  32'd1);
      chk("end_valid",  32'(o_valid), 32'd0);
      chk("end_busy",   32'(o_busy),  32'd0);
      @(negedge i_clk);
      chk("idle_done",  32'(o_done),  32'd0);
      chk("idle_valid", 32'(o_valid), 32'd0);
      chk("idle_busy",  32'(o_busy),  32'd0);
    end else begin
      i_reset = 1'b1;
      @(negedge i_clk);
      i_reset = 1'b0;
      chk_zero("rst_mid");
    end
  endtask

  initial begin
    int m, n, lp;
    i_reset = 1'b1;
    i_start = 1'b0;
    i_mode  = 2'd0;
    i_log2n = '0;
    i_loop  = 1'b0;
    i_ready = 1'b0;
    repeat (2) @(negedge i_clk);
    chk_zero("reset");
    i_reset = 1'b0;
    @(negedge i_clk);
    chk_zero("idle");

    run_frame(2, 3,  1'b0, 100, -1, -1);
    run_frame(1, 3,  1'b0, 100, -1, -1);
    run_frame(0, 3,  1'b0, 100, -1, -1);
    run_frame(3, 3,  1'b0, 100, -1, -1);
    run_frame(2, 12, 1'b0, 100, -1, -1);
    run_frame(2, 3,  1'b0, 100,  2, -1);
    run_frame(2, 2,  1'b1, 100, -1, 10);
    run_frame(0, 0,  1'b1, 100, -1, 5);
    run_frame(0, 0,  1'b0, 100, -1, -1);
    run_frame(0, 4,  1'b0, 100, -1, 5);
    run_frame(0, 15, 1'b0, 100, -1, -1);

    repeat (24) begin
      m  = $urandom_range(3);
      n  = $urandom_range(6);
      lp = ($urandom_range(3) == 0) ? 1 : 0;
      run_frame(m, n, 1'(lp), 60, -1, (lp != 0) ? int'($urandom_range(20, 5)) : -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
